// File: rtl/SB_codex_pkg.sv
// Shared sideband message codes, ACTIVE-handshake FSM states and lane-mode encodings.
package SB_codex_pkg;

   typedef enum logic [3:0] {
      SB_MSG_NONE         = 4'd0,
      SB_MBINIT_DONE_REQ  = 4'd1,
      SB_MBINIT_DONE_RESP = 4'd2,
      SB_LINKINIT_REQ     = 4'd3,
      SB_ACTIVE_REQ       = 4'd4,
      SB_ACTIVE_RESP      = 4'd5
   } SB_msg_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TX_REQ  = 3'd1,
      WAIT    = 3'd2,
      TX_RESP = 3'd3,
      ACTIVE  = 3'd4,
      ERROR   = 3'd5
   } active_state_t;

   typedef enum logic [1:0] {
      LANE_ALL     = 2'b00,
      LANE_LOWER   = 2'b01,
      LANE_UPPER   = 2'b10,
      LANE_ALL_ALT = 2'b11
   } lane_mode_t;

   // Mode 11 behaves as all-lanes; it is folded at latch time so downstream sees only three cases.
   function automatic lane_mode_t norm_lane_mode(input logic [1:0] raw);
      return (raw == 2'b11) ? LANE_ALL : lane_mode_t'(raw);
   endfunction

endpackage

// File: rtl/active_lane_gate.sv
// One-cycle register stage for mainband lanes; disabled half forced to zero, cleared when not enabled.
module active_lane_gate
   import SB_codex_pkg::*;
#(
   parameter int unsigned NUM_LANES = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  lane_mode_t           lane_mode_i,
   input  logic [NUM_LANES-1:0] data_i,
   input  logic                 valid_i,
   output logic [NUM_LANES-1:0] data_o,
   output logic                 valid_o
);

   logic [NUM_LANES-1:0] mask;
   logic [NUM_LANES-1:0] data_d, data_q;
   logic                 valid_d, valid_q;

   always_comb begin
      mask = '1;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         case (lane_mode_i)
            LANE_LOWER: mask[i] = (i < NUM_LANES / 2);
            LANE_UPPER: mask[i] = (i >= NUM_LANES / 2);
            default:    mask[i] = 1'b1;
         endcase
      end
   end

   always_comb begin
      data_d  = en_i ? (data_i & mask) : '0;
      valid_d = en_i & valid_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/active_ctrl.sv
// ACTIVE-state controller: sideband REQ/RESP handshake with retry, then lane-gated mainband pass-through.
module active_ctrl
   import SB_codex_pkg::*;
#(
   parameter int unsigned NUM_LANES = 16,
   parameter int unsigned RETRY_MAX = 3
) (
   input  logic                 clk_100MHz,
   input  logic                 reset,
   input  logic                 enable_i,
   input  logic [1:0]           lane_mode_i,
   output logic                 ACTIVE_done_o,
   output logic                 ACTIVE_error_o,
   input  logic [NUM_LANES-1:0] MB_TX_data_i,
   input  logic                 MB_TX_valid_i,
   output logic [NUM_LANES-1:0] MB_TX_dataPins_o,
   output logic                 MB_TX_validPin_o,
   input  logic [NUM_LANES-1:0] MB_RX_dataPins_i,
   input  logic                 MB_RX_validPin_i,
   output logic [NUM_LANES-1:0] MB_RX_data_o,
   output logic                 MB_RX_valid_o,
   output SB_msg_t              SB_TX_msg_o,
   output logic [63:0]          SB_TX_dataBus_o,
   output logic                 SB_TX_msg_valid_o,
   input  logic                 SB_TX_msg_sendNextFlag_i,
   input  SB_msg_t              SB_RX_msg_i,
   input  logic                 SB_RX_msg_valid_i,
   output logic                 SB_RX_msg_req_o,
   input  logic                 SBmessage_retry_timeout_flag,
   output logic                 reset_SBmessage_retry_timeout
);

   localparam int unsigned RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

   active_state_t state_d, state_q;
   logic [RW-1:0] retry_d, retry_q;
   logic          got_d, got_q, need_d, need_q, sent_d, sent_q;
   logic          tpend_d, tpend_q;
   lane_mode_t    lane_d, lane_q;
   logic          done_q, err_q, rto_q;
   logic          timeout;

   assign timeout = SBmessage_retry_timeout_flag | tpend_q;

   // A message arriving in WAIT is recorded first; a coincident timeout is held and judged next cycle.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      got_d   = got_q;
      need_d  = need_q;
      sent_d  = sent_q;
      tpend_d = tpend_q;
      lane_d  = lane_q;
      if (!enable_i) begin
         state_d = IDLE;
         tpend_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = TX_REQ;
               retry_d = '0;
               got_d   = 1'b0;
               need_d  = 1'b0;
               sent_d  = 1'b0;
               tpend_d = 1'b0;
               lane_d  = norm_lane_mode(lane_mode_i);
            end
            TX_REQ: if (SB_TX_msg_sendNextFlag_i) state_d = WAIT;
            TX_RESP: if (SB_TX_msg_sendNextFlag_i) begin
               state_d = WAIT;
               sent_d  = 1'b1;
            end
            WAIT: begin
               if (SB_RX_msg_valid_i) begin
                  if (SB_RX_msg_i == SB_ACTIVE_REQ)  need_d = 1'b1;
                  if (SB_RX_msg_i == SB_ACTIVE_RESP) got_d  = 1'b1;
                  if (SBmessage_retry_timeout_flag)  tpend_d = 1'b1;
               end else if (got_q && sent_q) begin
                  state_d = ACTIVE;
                  tpend_d = 1'b0;
               end else if (need_q && !sent_q) begin
                  state_d = TX_RESP;
                  tpend_d = 1'b0;
               end else if (timeout) begin
                  tpend_d = 1'b0;
                  if (retry_q == RETRY_LIM) begin
                     state_d = ERROR;
                  end else begin
                     state_d = TX_REQ;
                     retry_d = retry_q + 1'b1;
                  end
               end
            end
            ACTIVE, ERROR: state_d = state_q;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         retry_q <= '0;
         got_q   <= 1'b0;
         need_q  <= 1'b0;
         sent_q  <= 1'b0;
         tpend_q <= 1'b0;
         lane_q  <= LANE_ALL;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         got_q   <= got_d;
         need_q  <= need_d;
         sent_q  <= sent_d;
         tpend_q <= tpend_d;
         lane_q  <= lane_d;
         done_q  <= (state_d == ACTIVE);
         err_q   <= (state_d == ERROR);
         rto_q   <= (state_d == WAIT) && (state_q != WAIT);
      end
   end

   always_comb begin
      SB_TX_msg_o     = SB_MSG_NONE;
      SB_TX_dataBus_o = '0;
      if (state_q == TX_REQ || state_q == TX_RESP) begin
         SB_TX_msg_o          = (state_q == TX_RESP) ? SB_ACTIVE_RESP : SB_ACTIVE_REQ;
         SB_TX_dataBus_o[1:0] = lane_q;
      end
   end

   assign SB_TX_msg_valid_o             = (state_q == TX_REQ) || (state_q == TX_RESP);
   assign SB_RX_msg_req_o               = (state_q == WAIT);
   assign ACTIVE_done_o                 = done_q;
   assign ACTIVE_error_o                = err_q;
   assign reset_SBmessage_retry_timeout = rto_q;

   // Gates load on the next state so leaving ACTIVE clears the pins on the same edge.
   active_lane_gate #(.NUM_LANES(NUM_LANES)) u_tx_gate (
      .clk_i       (clk_100MHz),
      .rst_n_i     (reset),
      .en_i        (state_d == ACTIVE),
      .lane_mode_i (lane_q),
      .data_i      (MB_TX_data_i),
      .valid_i     (MB_TX_valid_i),
      .data_o      (MB_TX_dataPins_o),
      .valid_o     (MB_TX_validPin_o)
   );

   active_lane_gate #(.NUM_LANES(NUM_LANES)) u_rx_gate (
      .clk_i       (clk_100MHz),
      .rst_n_i     (reset),
      .en_i        (state_d == ACTIVE),
      .lane_mode_i (lane_q),
      .data_i      (MB_RX_dataPins_i),
      .valid_i     (MB_RX_validPin_i),
      .data_o      (MB_RX_data_o),
      .valid_o     (MB_RX_valid_o)
   );

endmodule

// File: tb/tb_active_ctrl.sv
// Scoreboard bench for active_ctrl: handshake, retry exhaustion, lane gating, reset and disable scenarios.
`timescale 1ns/1ps
module tb_active_ctrl;
   import SB_codex_pkg::*;

   localparam int unsigned NL   = 16;
   localparam int unsigned RMAX = 3;

   logic          clk_100MHz = 1'b0;
   logic          reset = 1'b1;
   logic          enable_i = 1'b0;
   logic [1:0]    lane_mode_i = 2'b00;
   logic          ACTIVE_done_o, ACTIVE_error_o;
   logic [NL-1:0] MB_TX_data_i = '0;
   logic          MB_TX_valid_i = 1'b0;
   logic [NL-1:0] MB_TX_dataPins_o;
   logic          MB_TX_validPin_o;
   logic [NL-1:0] MB_RX_dataPins_i = '0;
   logic          MB_RX_validPin_i = 1'b0;
   logic [NL-1:0] MB_RX_data_o;
   logic          MB_RX_valid_o;
   SB_msg_t       SB_TX_msg_o;
   logic [63:0]   SB_TX_dataBus_o;
   logic          SB_TX_msg_valid_o;
   logic          SB_TX_msg_sendNextFlag_i = 1'b0;
   SB_msg_t       SB_RX_msg_i = SB_MSG_NONE;
   logic          SB_RX_msg_valid_i = 1'b0;
   logic          SB_RX_msg_req_o;
   logic          SBmessage_retry_timeout_flag = 1'b0;
   logic          reset_SBmessage_retry_timeout;

   active_ctrl #(.NUM_LANES(NL), .RETRY_MAX(RMAX)) dut (
      .clk_100MHz                    (clk_100MHz),
      .reset                         (reset),
      .enable_i                      (enable_i),
      .lane_mode_i                   (lane_mode_i),
      .ACTIVE_done_o                 (ACTIVE_done_o),
      .ACTIVE_error_o                (ACTIVE_error_o),
      .MB_TX_data_i                  (MB_TX_data_i),
      .MB_TX_valid_i                 (MB_TX_valid_i),
      .MB_TX_dataPins_o              (MB_TX_dataPins_o),
      .MB_TX_validPin_o              (MB_TX_validPin_o),
      .MB_RX_dataPins_i              (MB_RX_dataPins_i),
      .MB_RX_validPin_i              (MB_RX_validPin_i),
      .MB_RX_data_o                  (MB_RX_data_o),
      .MB_RX_valid_o                 (MB_RX_valid_o),
      .SB_TX_msg_o                   (SB_TX_msg_o),
      .SB_TX_dataBus_o               (SB_TX_dataBus_o),
      .SB_TX_msg_valid_o             (SB_TX_msg_valid_o),
      .SB_TX_msg_sendNextFlag_i      (SB_TX_msg_sendNextFlag_i),
      .SB_RX_msg_i                   (SB_RX_msg_i),
      .SB_RX_msg_valid_i             (SB_RX_msg_valid_i),
      .SB_RX_msg_req_o               (SB_RX_msg_req_o),
      .SBmessage_retry_timeout_flag  (SBmessage_retry_timeout_flag),
      .reset_SBmessage_retry_timeout (reset_SBmessage_retry_timeout)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   typedef struct {
      SB_msg_t     msg;
      logic [63:0] bus;
   } sb_exp_t;

   sb_exp_t       sb_q[$];
   logic [NL-1:0] tx_q[$];
   logic [NL-1:0] rx_q[$];
   int checks = 0;
   int errors = 0;
   int msg_rises = 0;
   int rto_pulses = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=missing required=present", name);
   endtask

   function automatic logic [63:0] bus_exp(input logic [1:0] mode);
      return {62'd0, (mode == 2'b11) ? 2'b00 : mode};
   endfunction

   function automatic logic [NL-1:0] gate_exp(input logic [1:0] mode, input logic [NL-1:0] d);
      case (mode)
         2'b01:   return d & 16'h00FF;
         2'b10:   return d & 16'hFF00;
         default: return d;
      endcase
   endfunction

   // Monitor: pops expectations whenever the DUT presents a transfer or valid data.
   initial begin
      logic    prev_valid;
      sb_exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk_100MHz);
         if (!reset) begin
            prev_valid = 1'b0;
         end else begin
            if (SB_TX_msg_valid_o && !prev_valid) msg_rises++;
            prev_valid = SB_TX_msg_valid_o;
            if (reset_SBmessage_retry_timeout) rto_pulses++;
            if (SB_TX_msg_valid_o && SB_TX_msg_sendNextFlag_i) begin
               if (sb_q.size() == 0) fail_now("sb_expected_entry");
               else begin
                  e = sb_q.pop_front();
                  check("sb_msg", 64'(SB_TX_msg_o), 64'(e.msg));
                  check("sb_bus", SB_TX_dataBus_o, e.bus);
               end
            end
            if (MB_TX_validPin_o) begin
               if (tx_q.size() == 0) fail_now("tx_expected_entry");
               else check("tx_pins", 64'(MB_TX_dataPins_o), 64'(tx_q.pop_front()));
            end
            if (MB_RX_valid_o) begin
               if (rx_q.size() == 0) fail_now("rx_expected_entry");
               else check("rx_data", 64'(MB_RX_data_o), 64'(rx_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return SB_TX_msg_valid_o;
         1:       return SB_RX_msg_req_o;
         2:       return ACTIVE_done_o;
         default: return ACTIVE_error_o;
      endcase
   endfunction

   task automatic wait_sig(input string name, input int sel);
      int n;
      n = 0;
      while (!sig(sel) && n < 50) begin
         tick();
         n++;
      end
      if (!sig(sel)) fail_now({"wait_", name});
   endtask

   task automatic accept_msg(input int delay);
      wait_sig("tx_valid", 0);
      repeat (delay) tick();
      SB_TX_msg_sendNextFlag_i = 1'b1;
      tick();
      SB_TX_msg_sendNextFlag_i = 1'b0;
   endtask

   task automatic rx_msg(input SB_msg_t m);
      wait_sig("rx_req", 1);
      SB_RX_msg_i       = m;
      SB_RX_msg_valid_i = 1'b1;
      tick();
      SB_RX_msg_valid_i = 1'b0;
   endtask

   task automatic pulse_timeout();
      wait_sig("rx_req_to", 1);
      SBmessage_retry_timeout_flag = 1'b1;
      tick();
      SBmessage_retry_timeout_flag = 1'b0;
   endtask

   task automatic handshake(input logic [1:0] mode);
      msg_rises   = 0;
      rto_pulses  = 0;
      lane_mode_i = mode;
      enable_i    = 1'b1;
      sb_q.push_back('{SB_ACTIVE_REQ, bus_exp(mode)});
      accept_msg(2);
      lane_mode_i = 2'($urandom_range(0, 3));
      rx_msg(SB_MBINIT_DONE_REQ);
      rx_msg(SB_ACTIVE_REQ);
      sb_q.push_back('{SB_ACTIVE_RESP, bus_exp(mode)});
      accept_msg(2);
      rx_msg(SB_ACTIVE_RESP);
      wait_sig("done", 2);
      check("hs_done", 64'(ACTIVE_done_o), 64'd1);
      check("hs_error", 64'(ACTIVE_error_o), 64'd0);
      check("hs_msg_count", 64'(msg_rises), 64'd2);
      check("hs_rto_pulses", 64'(rto_pulses), 64'd2);
      check("hs_sb_pending", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic data_phase(input logic [1:0] mode);
      logic [NL-1:0] td, rd;
      logic          tv, rv;
      for (int i = 0; i < 20; i++) begin
         td = (i == 0) ? 16'hFFFF : NL'($urandom);
         rd = (i == 0) ? 16'hFFFF : NL'($urandom);
         tv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         rv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         MB_TX_data_i     = td;
         MB_TX_valid_i    = tv;
         MB_RX_dataPins_i = rd;
         MB_RX_validPin_i = rv;
         lane_mode_i      = 2'($urandom_range(0, 3));
         if (tv) tx_q.push_back(gate_exp(mode, td));
         if (rv) rx_q.push_back(gate_exp(mode, rd));
         tick();
      end
      MB_TX_valid_i    = 1'b0;
      MB_RX_validPin_i = 1'b0;
      tick();
      check("tx_pending", 64'(tx_q.size()), 64'd0);
      check("rx_pending", 64'(rx_q.size()), 64'd0);
   endtask

   task automatic disable_link();
      enable_i         = 1'b0;
      MB_TX_data_i     = NL'($urandom) | 16'h0101;
      MB_TX_valid_i    = 1'b1;
      MB_RX_dataPins_i = NL'($urandom) | 16'h8080;
      MB_RX_validPin_i = 1'b1;
      tick();
      check("dis_done", 64'(ACTIVE_done_o), 64'd0);
      check("dis_tx_pins", 64'({MB_TX_validPin_o, MB_TX_dataPins_o}), 64'd0);
      check("dis_rx_data", 64'({MB_RX_valid_o, MB_RX_data_o}), 64'd0);
      MB_TX_valid_i    = 1'b0;
      MB_RX_validPin_i = 1'b0;
      tick();
   endtask

   task automatic retry_test();
      logic [1:0] mode;
      mode        = 2'($urandom_range(0, 3));
      msg_rises   = 0;
      rto_pulses  = 0;
      lane_mode_i = mode;
      enable_i    = 1'b1;
      sb_q.push_back('{SB_ACTIVE_REQ, bus_exp(mode)});
      accept_msg(1);
      for (int t = 0; t <= int'(RMAX); t++) begin
         pulse_timeout();
         if (t < int'(RMAX)) begin
            sb_q.push_back('{SB_ACTIVE_REQ, bus_exp(mode)});
            accept_msg($urandom_range(0, 3));
         end
      end
      wait_sig("error", 3);
      check("rt_error", 64'(ACTIVE_error_o), 64'd1);
      check("rt_done", 64'(ACTIVE_done_o), 64'd0);
      check("rt_req_count", 64'(msg_rises), 64'(RMAX + 1));
      check("rt_rto_pulses", 64'(rto_pulses), 64'(RMAX + 1));
      check("rt_msg_valid", 64'(SB_TX_msg_valid_o), 64'd0);
      enable_i = 1'b0;
      tick();
      check("rt_error_cleared", 64'(ACTIVE_error_o), 64'd0);
   endtask

   task automatic simul_test();
      msg_rises   = 0;
      rto_pulses  = 0;
      lane_mode_i = 2'b10;
      enable_i    = 1'b1;
      sb_q.push_back('{SB_ACTIVE_REQ, bus_exp(2'b10)});
      accept_msg(2);
      rx_msg(SB_ACTIVE_REQ);
      sb_q.push_back('{SB_ACTIVE_RESP, bus_exp(2'b10)});
      accept_msg(2);
      wait_sig("rx_req_sim", 1);
      SB_RX_msg_i                  = SB_ACTIVE_RESP;
      SB_RX_msg_valid_i            = 1'b1;
      SBmessage_retry_timeout_flag = 1'b1;
      tick();
      SB_RX_msg_valid_i            = 1'b0;
      SBmessage_retry_timeout_flag = 1'b0;
      wait_sig("done_sim", 2);
      check("sim_done", 64'(ACTIVE_done_o), 64'd1);
      check("sim_msg_count", 64'(msg_rises), 64'd2);
      check("sim_msg_valid", 64'(SB_TX_msg_valid_o), 64'd0);
   endtask

   task automatic reset_test();
      lane_mode_i = 2'b01;
      enable_i    = 1'b1;
      sb_q.push_back('{SB_ACTIVE_REQ, bus_exp(2'b01)});
      wait_sig("tx_valid_rst", 0);
      reset = 1'b0;
      #1;
      check("rst_msg_valid", 64'(SB_TX_msg_valid_o), 64'd0);
      check("rst_bus", SB_TX_dataBus_o, 64'd0);
      check("rst_rx_req", 64'(SB_RX_msg_req_o), 64'd0);
      sb_q.delete();
      enable_i = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      check("post_rst_idle", 64'({SB_TX_msg_valid_o, SB_RX_msg_req_o, ACTIVE_done_o, ACTIVE_error_o}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] modes [4];
      modes = '{2'b01, 2'b10, 2'b00, 2'b11};
      #2;
      reset = 1'b0;
      #1;
      check("reset_done", 64'(ACTIVE_done_o), 64'd0);
      check("reset_error", 64'(ACTIVE_error_o), 64'd0);
      check("reset_sb_tx", 64'({SB_TX_msg_valid_o, SB_TX_dataBus_o[1:0]}), 64'd0);
      check("reset_rx_req", 64'(SB_RX_msg_req_o), 64'd0);
      check("reset_rto", 64'(reset_SBmessage_retry_timeout), 64'd0);
      check("reset_mb", 64'({MB_TX_validPin_o, MB_TX_dataPins_o, MB_RX_valid_o, MB_RX_data_o}), 64'd0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("idle_after_release", 64'({SB_TX_msg_valid_o, ACTIVE_done_o}), 64'd0);
      for (int m = 0; m < 4; m++) begin
         handshake(modes[m]);
         data_phase(modes[m]);
         disable_link();
      end
      retry_test();
      simul_test();
      disable_link();
      reset_test();
      handshake(2'b01);
      data_phase(2'b01);
      disable_link();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
